// File: rtl/vga_colour_source_pkg.sv
// Shared definitions for the VGA background colour source: mode encodings and the
// fixed 8-entry rrr_ggg_bb palette.
package vga_colour_source_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL  = 2'd0,
        MODE_PALETTE = 2'd1,
        MODE_AUTO    = 2'd2,
        MODE_ILLEGAL = 2'd3
    } mode_e;

    localparam logic [7:0] RESET_COLOUR = 8'hFF;

    function automatic logic [7:0] palette_colour(input logic [2:0] idx);
        logic [7:0] colour;
        case (idx)
            3'd0:    colour = 8'hFF;
            3'd1:    colour = 8'hE0;
            3'd2:    colour = 8'h1C;
            3'd3:    colour = 8'h03;
            3'd4:    colour = 8'hFC;
            3'd5:    colour = 8'h1F;
            3'd6:    colour = 8'hE3;
            default: colour = 8'h00;
        endcase
        return colour;
    endfunction

    // The unused encoding falls back to MANUAL so a corrupted mode recovers in one step.
    function automatic mode_e next_mode(input mode_e cur);
        mode_e nxt;
        case (cur)
            MODE_MANUAL:  nxt = MODE_PALETTE;
            MODE_PALETTE: nxt = MODE_AUTO;
            default:      nxt = MODE_MANUAL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/vga_colour_source_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a one-clock
// press pulse on the accepted released->pressed transition.
module vga_colour_source_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    logic w_differs;
    logic w_accept;

    // The counter only runs while the sampled input disagrees with the accepted level,
    // so any agreeing sample restarts the stability window.
    assign w_differs = (r_sync2 != r_level);
    assign w_accept  = w_differs && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_press <= w_accept & r_sync2;
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/vga_colour_source.sv
// Background colour source for the VGA core: chooses switches, stepped palette or
// auto-cycling palette, and applies every change only at frame start.
module vga_colour_source
    import vga_colour_source_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int AUTO_FRAMES     = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vs,
    input  logic [7:0] sw,
    input  logic       btn_mode,
    input  logic       btn_next,
    output logic [7:0] data,
    output logic [1:0] mode,
    output logic       frame_tick
);

    localparam int                FCNT_W    = $clog2(AUTO_FRAMES + 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(AUTO_FRAMES - 1);

    logic              r_vs_s1;
    logic              r_vs_s2;
    logic              r_vs_prev;
    logic [7:0]        r_sw_s1;
    logic [7:0]        r_sw_s2;
    logic              r_frame_tick;
    mode_e             r_mode;
    logic [2:0]        r_index;
    logic [FCNT_W-1:0] r_frame_cnt;
    logic              r_pend_mode;
    logic              r_pend_next;
    logic [7:0]        r_data;

    logic              w_vs_fall;
    logic              w_mode_press;
    logic              w_next_press;
    mode_e             w_mode_n;
    logic [2:0]        w_index_n;
    logic [FCNT_W-1:0] w_frame_cnt_n;
    logic [7:0]        w_data_n;
    logic              w_pend_mode_n;
    logic              w_pend_next_n;

    vga_colour_source_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_mode (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_mode),
        .level(),
        .press(w_mode_press)
    );

    vga_colour_source_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_next (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_next),
        .level(),
        .press(w_next_press)
    );

    assign w_vs_fall = r_vs_prev & ~r_vs_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs_s1      <= 1'b1;
            r_vs_s2      <= 1'b1;
            r_vs_prev    <= 1'b1;
            r_sw_s1      <= 8'h00;
            r_sw_s2      <= 8'h00;
            r_frame_tick <= 1'b0;
        end else begin
            r_vs_s1      <= vs;
            r_vs_s2      <= r_vs_s1;
            r_vs_prev    <= r_vs_s2;
            r_sw_s1      <= sw;
            r_sw_s2      <= r_sw_s1;
            r_frame_tick <= w_vs_fall;
        end
    end

    // A press landing on the tick cycle survives the clear and is served next frame.
    always_comb begin
        w_pend_mode_n = (r_frame_tick ? 1'b0 : r_pend_mode) | w_mode_press;
        w_pend_next_n = (r_frame_tick ? 1'b0 : r_pend_next) | w_next_press;
    end

    always_comb begin
        w_mode_n      = r_mode;
        w_index_n     = r_index;
        w_frame_cnt_n = r_frame_cnt;
        w_data_n      = r_data;
        if (r_frame_tick) begin
            if (r_pend_mode) begin
                w_mode_n      = next_mode(r_mode);
                w_frame_cnt_n = '0;
            end else if (r_mode == MODE_ILLEGAL) begin
                w_mode_n = MODE_MANUAL;
            end else if ((r_mode == MODE_PALETTE) && r_pend_next) begin
                w_index_n = r_index + 3'd1;
            end else if (r_mode == MODE_AUTO) begin
                if (r_frame_cnt == FCNT_LAST) begin
                    w_frame_cnt_n = '0;
                    w_index_n     = r_index + 3'd1;
                end else begin
                    w_frame_cnt_n = r_frame_cnt + FCNT_W'(1);
                end
            end
            w_data_n = (w_mode_n == MODE_MANUAL) ? r_sw_s2 : palette_colour(w_index_n);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode      <= MODE_MANUAL;
            r_index     <= 3'd0;
            r_frame_cnt <= '0;
            r_pend_mode <= 1'b0;
            r_pend_next <= 1'b0;
            r_data      <= RESET_COLOUR;
        end else begin
            r_mode      <= w_mode_n;
            r_index     <= w_index_n;
            r_frame_cnt <= w_frame_cnt_n;
            r_pend_mode <= w_pend_mode_n;
            r_pend_next <= w_pend_next_n;
            r_data      <= w_data_n;
        end
    end

    assign data       = r_data;
    assign mode       = r_mode;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_colour_source.sv
// Bench for vga_colour_source: directed scenarios plus random frames, checked against
// a frame-level model of the colour/mode rules.
module tb_vga_colour_source;

    localparam int DB = 4;
    localparam int AF = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       vs;
    logic [7:0] sw;
    logic       btn_mode;
    logic       btn_next;
    logic [7:0] data;
    logic [1:0] mode;
    logic       frame_tick;

    int n_cmp = 0;
    int n_mis = 0;

    int         m_mode;
    int         m_idx;
    int         m_fcnt;
    bit         p_mode;
    bit         p_next;
    logic [7:0] m_data;
    logic [7:0] pal [8] = '{8'hFF, 8'hE0, 8'h1C, 8'h03, 8'hFC, 8'h1F, 8'hE3, 8'h00};

    always #5 clk = ~clk;

    vga_colour_source #(
        .DEBOUNCE_CYCLES(DB),
        .AUTO_FRAMES    (AF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vs        (vs),
        .sw        (sw),
        .btn_mode  (btn_mode),
        .btn_next  (btn_next),
        .data      (data),
        .mode      (mode),
        .frame_tick(frame_tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_fcnt = 0;
        p_mode = 0; p_next = 0;
        m_data = 8'hFF;
    endtask

    task automatic model_tick();
        if (p_mode) begin
            m_mode = (m_mode + 1) % 3;
            m_fcnt = 0;
        end else if (m_mode == 1 && p_next) begin
            m_idx = (m_idx + 1) % 8;
        end else if (m_mode == 2) begin
            if (m_fcnt == AF - 1) begin
                m_fcnt = 0;
                m_idx  = (m_idx + 1) % 8;
            end else begin
                m_fcnt++;
            end
        end
        p_mode = 0;
        p_next = 0;
        m_data = (m_mode == 0) ? sw : pal[m_idx];
    endtask

    task automatic set_btn(input bit which, input logic v);
        if (which) btn_mode = v;
        else       btn_next = v;
    endtask

    // Bouncy press: a few 1-clk blips, a solid hold, then a solid release.
    task automatic press(input bit which);
        int b;
        b = $urandom_range(0, 3);
        for (int k = 0; k < b; k++) begin
            set_btn(which, 1'b1); step(1);
            set_btn(which, 1'b0); step(1);
        end
        set_btn(which, 1'b1); step(12);
        set_btn(which, 1'b0); step(12);
        if (which) p_mode = 1;
        else       p_next = 1;
    endtask

    task automatic vs_fall_and_check(input string tag);
        int n;
        vs = 1'b0;
        n  = 0;
        do begin
            step(1);
            n++;
        end while (!frame_tick && n < 8);
        chk({tag, ":tick_lat"}, n, 3);
    endtask

    task automatic after_tick_checks(input string tag);
        step(1);
        chk({tag, ":tick_width"}, frame_tick, 1'b0);
        chk({tag, ":data"}, data, m_data);
        chk({tag, ":mode"}, mode, m_mode);
        step(2);
        vs = 1'b1;
        step(4);
    endtask

    task automatic frame(input bit pm, input int nn, input logic [7:0] swv, input string tag);
        sw = swv;
        step(3);
        chk({tag, ":hold"}, data, m_data);
        if (pm) press(1'b1);
        for (int k = 0; k < nn; k++) press(1'b0);
        step($urandom_range(1, 4));
        chk({tag, ":hold2"}, data, m_data);
        chk({tag, ":mode_hold"}, mode, m_mode);
        vs_fall_and_check(tag);
        model_tick();
        after_tick_checks(tag);
    endtask

    // btn_next press event lands exactly on the frame_tick cycle.
    task automatic coincide_next(input string tag);
        btn_next = 1'b1;
        step(3);
        vs_fall_and_check(tag);
        model_tick();
        p_next = 1;
        step(1);
        chk({tag, ":tick_width"}, frame_tick, 1'b0);
        chk({tag, ":data"}, data, m_data);
        chk({tag, ":mode"}, mode, m_mode);
        step(2);
        vs = 1'b1;
        step(6);
        btn_next = 1'b0;
        step(12);
    endtask

    initial begin
        int t;
        int k;
        rst = 1'b1; vs = 1'b1; sw = 8'h00; btn_mode = 1'b0; btn_next = 1'b0;
        model_reset();
        step(3);
        chk("init:data", data, 8'hFF);
        chk("init:mode", mode, 2'd0);
        chk("init:tick", frame_tick, 1'b0);
        rst = 1'b0;
        step(3);

        frame(1'b0, 0, 8'hE0, "manual_sw");

        btn_mode = 1'b1; step(3); btn_mode = 1'b0; step(8);
        frame(1'b0, 0, 8'hE0, "glitch");
        frame(1'b1, 0, 8'h5A, "to_palette");

        frame(1'b0, 3, 8'h5A, "pal_coalesce");
        for (int i = 0; i < 6; i++) frame(1'b0, 1, 8'h5A, "pal_step");
        frame(1'b0, 1, 8'h5A, "pal_wrap");

        frame(1'b1, 0, 8'h33, "to_auto");
        for (int i = 0; i < 26; i++) frame(1'b0, 0, 8'h33, "auto");

        k = 0;
        while (!(m_mode == 2 && m_idx == 5) && k < 40) begin
            frame(1'b0, 0, 8'h33, "auto_seek");
            k++;
        end
        chk("seek:idx", m_idx, 5);
        step(5);
        #3 rst = 1'b1;
        #1;
        chk("rst:data", data, 8'hFF);
        chk("rst:mode", mode, 2'd0);
        chk("rst:tick", frame_tick, 1'b0);
        model_reset();
        step(2);
        rst = 1'b0;
        t = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (frame_tick) t++;
        end
        chk("rst:no_tick", t, 0);
        frame(1'b1, 0, 8'h11, "rst_idx0");

        frame(1'b0, 2, 8'h11, "pal_again");
        frame(1'b1, 1, 8'h11, "both_btn");
        frame(1'b1, 0, 8'h22, "to_manual");
        frame(1'b1, 0, 8'h22, "to_pal2");
        coincide_next("coincide");
        frame(1'b0, 0, 8'h22, "coincide_next");

        for (int i = 0; i < 30; i++) begin
            frame(($urandom % 4) == 0, $urandom_range(0, 2), 8'($urandom), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
